bp_me_stream_pump_in_mc: RTL

Multi-channel inbound BedRock Stream pump for ME-side FSMs such as cache engines and I/O bridges. Buffers `num_chan_p` independent inbound streams, picks one message at a time with round-robin arbitration, and exposes the selected message to one FSM consumer. Provides per-beat address, new/critical/last strobes and 1:N read expansion. The grant holds until the message's last beat is consumed, so beats from different messages never interleave.

---
 rtl/bp_me_stream_pump_in_mc.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bp_me_stream_pump_in_mc.sv
// Multi-channel inbound BedRock stream pump: per-channel beat FIFOs, round-robin message arbitration, 1:N read expansion.
// Optional macro BP_ME_STREAM_PUMP_IN_MC_CRIT_WRAP_EN selects critical-word-first wrapped addressing.
module bp_me_stream_pump_in_mc
  #(parameter int paddr_width_p = 40
  , parameter int bedrock_block_width_p = 512
  , parameter int num_chan_p = 2
  , parameter int data_width_p = 64
  , parameter int fifo_els_p = 2
  , parameter int payload_width_p = 8
  , parameter logic [15:0] msg_stream_mask_p = '0
  , parameter logic [15:0] fsm_stream_mask_p = '0
  // header layout, LSB first: msg_type[4], subop[4], addr[paddr], size[3], payload
  , localparam int header_width_lp = 11 + paddr_width_p + payload_width_p
  , localparam int chan_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
  )
  (input  logic                                          clk_i
  , input  logic                                         reset_n_i
  , input  logic [num_chan_p-1:0][header_width_lp-1:0]   msg_header_i
  , input  logic [num_chan_p-1:0][data_width_p-1:0]      msg_data_i
  , input  logic [num_chan_p-1:0]                        msg_v_i
  , output logic [num_chan_p-1:0]                        msg_ready_and_o
  , output logic [header_width_lp-1:0]                   fsm_header_o
  , output logic [data_width_p-1:0]                      fsm_data_o
  , output logic                                         fsm_v_o
  , input  logic                                         fsm_yumi_i
  , output logic [chan_width_lp-1:0]                     fsm_chan_o
  , output logic [paddr_width_p-1:0]                     fsm_addr_o
  , output logic                                         fsm_new_o
  , output logic                                         fsm_critical_o
  , output logic                                         fsm_last_o
  );

  localparam int unsigned beat_lg = $clog2(data_width_p/8);
  localparam int cnt_w   = (bedrock_block_width_p > data_width_p) ? $clog2(bedrock_block_width_p/data_width_p) : 1;
  localparam int ptr_w   = $clog2(fifo_els_p);
  localparam int occ_w   = $clog2(fifo_els_p+1);
  localparam int entry_w = header_width_lp + data_width_p;

  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(fifo_els_p - 1);
  localparam logic [occ_w-1:0] full_occ = occ_w'(fifo_els_p);
  localparam logic [paddr_width_p-1:0] one_a   = paddr_width_p'(1);
  localparam logic [paddr_width_p-1:0] beat_lo = paddr_width_p'(data_width_p/8 - 1);

  localparam logic [0:0] st_idle   = 1'b0;
  localparam logic [0:0] st_locked = 1'b1;

  logic [entry_w-1:0] mem [num_chan_p][fifo_els_p];
  logic [ptr_w-1:0]   rd_ptr [num_chan_p];
  logic [ptr_w-1:0]   wr_ptr [num_chan_p];
  logic [occ_w-1:0]   occ [num_chan_p];
  logic [num_chan_p-1:0] empty, full, push, pop;

  logic [0:0]               state;
  logic [chan_width_lp-1:0] rr, lock, arb_grant, grant;
  logic [cnt_w-1:0]         cnt, ss;
  logic [31:0]              scan;
  logic                     found, one_to_n, deq;
  logic [entry_w-1:0]       head;

  logic [3:0]               msg_type;
  logic [2:0]               hdr_size;
  logic [paddr_width_p-1:0] hdr_addr, win_mask, beat_addr, base, step;
  logic [31:0]              win_lg;

  always_comb begin
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      empty[c] = (occ[c] == '0);
      full[c]  = (occ[c] == full_occ);
    end
  end

  // Ready depends only on occupancy, never on the consumer's yumi.
  assign msg_ready_and_o = {num_chan_p{reset_n_i}} & ~full;
  assign push = msg_v_i & msg_ready_and_o;

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < num_chan_p; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= {msg_header_i[c], msg_data_i[c]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned c = 0; c < num_chan_p; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        occ[c]    <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < num_chan_p; c++) begin
        if (push[c]) wr_ptr[c] <= (wr_ptr[c] == last_ptr) ? '0 : wr_ptr[c] + ptr_w'(1);
        if (pop[c])  rd_ptr[c] <= (rd_ptr[c] == last_ptr) ? '0 : rd_ptr[c] + ptr_w'(1);
        if (push[c] & ~pop[c])      occ[c] <= occ[c] + occ_w'(1);
        else if (~push[c] & pop[c]) occ[c] <= occ[c] - occ_w'(1);
      end
    end
  end

  always_comb begin
    arb_grant = rr;
    found     = 1'b0;
    scan      = '0;
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      scan = 32'(rr) + i;
      if (scan >= 32'(num_chan_p)) scan = scan - 32'(num_chan_p);
      if (!found && !empty[chan_width_lp'(scan)]) begin
        arb_grant = chan_width_lp'(scan);
        found     = 1'b1;
      end
    end
  end

  assign grant        = (state == st_locked) ? lock : arb_grant;
  assign head         = mem[grant][rd_ptr[grant]];
  assign fsm_header_o = head[entry_w-1 -: header_width_lp];
  assign fsm_data_o   = head[data_width_p-1:0];
  assign fsm_v_o      = ~empty[grant];
  assign fsm_chan_o   = grant;

  assign msg_type = fsm_header_o[3:0];
  assign hdr_addr = fsm_header_o[8 +: paddr_width_p];
  assign hdr_size = fsm_header_o[8+paddr_width_p +: 3];

  always_comb begin
    ss = '0;
    if (32'(hdr_size) > beat_lg) ss = cnt_w'((32'd1 << (32'(hdr_size) - beat_lg)) - 32'd1);
  end

  assign one_to_n   = ~msg_stream_mask_p[msg_type] & fsm_stream_mask_p[msg_type] & (ss != '0);
  assign fsm_new_o  = (cnt == '0);
  assign fsm_last_o = fsm_v_o & (cnt == ss);
  // A 1:N head is replayed for every beat and only leaves the FIFO with the last one.
  assign deq        = fsm_yumi_i & (~one_to_n | fsm_last_o);

  always_comb begin
    pop        = '0;
    pop[grant] = deq;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= st_idle;
      rr    <= '0;
      lock  <= '0;
      cnt   <= '0;
    end else if (fsm_yumi_i) begin
      if (fsm_last_o) begin
        state <= st_idle;
        cnt   <= '0;
        rr    <= (grant == chan_width_lp'(num_chan_p - 1)) ? '0 : grant + chan_width_lp'(1);
      end else begin
        state <= st_locked;
        lock  <= grant;
        cnt   <= cnt + cnt_w'(1);
      end
    end
  end

  always_comb begin
    win_lg    = (32'(hdr_size) > beat_lg) ? 32'(hdr_size) : beat_lg;
    win_mask  = (one_a << win_lg) - one_a;
    beat_addr = hdr_addr & ~beat_lo;
    base      = hdr_addr & ~win_mask;
    step      = paddr_width_p'(cnt) << beat_lg;
`ifdef BP_ME_STREAM_PUMP_IN_MC_CRIT_WRAP_EN
    fsm_addr_o     = base | ((beat_addr + step) & win_mask);
    fsm_critical_o = fsm_v_o & fsm_new_o;
`else
    fsm_addr_o     = base | step;
    fsm_critical_o = fsm_v_o & (fsm_addr_o == beat_addr);
`endif
  end

endmodule
